// File: rtl/adc_capture_avg_pkg.sv
// Shared constants and helpers for the ADC capture / moving-average front end.
package adc_capture_avg_pkg;

    localparam int unsigned ADC_W     = 8;
    localparam int unsigned ACC_W     = 12;
    localparam int unsigned DF_W      = 32;
    localparam int unsigned WIN_LOG2  = ACC_W - ADC_W;
    localparam int unsigned WIN_DEPTH = 1 << WIN_LOG2;
    localparam int unsigned K_W       = $clog2(WIN_LOG2);

    // Delay-line index of the sample leaving a 2^k window.
    function automatic logic [WIN_LOG2-1:0] win_last_idx(input logic [K_W-1:0] k_in);
        logic [31:0] span;
        span = (32'd1 << k_in) - 32'd1;
        return span[WIN_LOG2-1:0];
    endfunction

endpackage

// File: rtl/adc_capture_avg_ma_sliding_window.sv
// Sliding-window moving average: 16-deep delay line, running accumulator, power-of-two divide.
module ma_sliding_window
    import adc_capture_avg_pkg::*;
#(
    parameter int unsigned BITS_ADC  = ADC_W,
    parameter int unsigned BITS_ACUM = ACC_W,
    parameter int unsigned K_WIDTH   = K_W
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic [K_WIDTH-1:0]   k_i,
    input  logic [BITS_ADC-1:0]  sample_i,
    input  logic                 stb_i,
    output logic [BITS_ADC-1:0]  avg_o,
    output logic                 rdy_o
);

    logic [BITS_ADC-1:0]  dl_q [WIN_DEPTH];
    logic [BITS_ADC-1:0]  dl_d [WIN_DEPTH];
    logic [BITS_ACUM-1:0] acc_q, acc_d;
    logic [BITS_ADC-1:0]  avg_q, avg_d;
    logic                 rdy_q, rdy_d;
    logic [BITS_ADC-1:0]  old_s;
    logic [BITS_ACUM-1:0] sum_s;

    // Next-state for the window: add newest sample, drop the one leaving the 2^k window.
    always_comb begin
        old_s = dl_q[win_last_idx(k_i)];
        sum_s = acc_q + BITS_ACUM'(sample_i) - BITS_ACUM'(old_s);
        dl_d  = dl_q;
        acc_d = acc_q;
        avg_d = avg_q;
        rdy_d = 1'b0;
        if (clear_i) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                dl_d[i] = '0;
            end
            acc_d = '0;
            avg_d = '0;
        end else if (stb_i) begin
            dl_d[0] = sample_i;
            for (int i = 1; i < WIN_DEPTH; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            acc_d = sum_s;
            avg_d = BITS_ADC'(sum_s >> k_i);
            rdy_d = 1'b1;
        end else begin
            rdy_d = 1'b0;
        end
    end

    // Window state registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                dl_q[i] <= '0;
            end
            acc_q <= '0;
            avg_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            dl_q  <= dl_d;
            acc_q <= acc_d;
            avg_q <= avg_d;
            rdy_q <= rdy_d;
        end
    end

    assign avg_o = avg_q;
    assign rdy_o = rdy_q;

endmodule

// File: rtl/adc_capture_avg.sv
// Parallel-ADC front end: generates the ADC sample clock, captures one sample per period
// on the falling clk_o transition and feeds it to the moving-average filter.
module adc_capture_avg
    import adc_capture_avg_pkg::*;
#(
    parameter int unsigned BITS_ADC  = ADC_W,
    parameter int unsigned DF_WIDTH  = DF_W,
    parameter int unsigned BITS_ACUM = ACC_W,
    localparam int unsigned K_WIDTH  = $clog2(BITS_ACUM - BITS_ADC)
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic [DF_WIDTH-1:0]  decimation_factor,
    input  logic [K_WIDTH-1:0]   k,
    input  logic [BITS_ADC-1:0]  adc_data_i,
    output logic                 adc_oe,
    output logic                 clk_o,
    output logic [BITS_ADC-1:0]  sample_out,
    output logic                 rdy_out
);

    logic [DF_WIDTH-1:0] cnt_q, cnt_d;
    logic                clk_o_q, clk_o_d;
    logic [BITS_ADC-1:0] cap_q, cap_d;
    logic                cap_stb_q, cap_stb_d;
    logic                at_top_s;

    // Divider and capture next-state; the bus is sampled half a period after the ADC latched it.
    always_comb begin
        at_top_s  = (cnt_q == decimation_factor);
        cnt_d     = cnt_q;
        clk_o_d   = clk_o_q;
        cap_d     = cap_q;
        cap_stb_d = 1'b0;
        if (clear_i) begin
            cnt_d     = '0;
            clk_o_d   = 1'b0;
            cap_d     = '0;
            cap_stb_d = 1'b0;
        end else begin
            if (at_top_s) begin
                cnt_d   = '0;
                clk_o_d = ~clk_o_q;
            end else begin
                cnt_d   = cnt_q + DF_WIDTH'(1);
            end
            if (at_top_s && clk_o_q) begin
                cap_d     = adc_data_i;
                cap_stb_d = 1'b1;
            end else begin
                cap_stb_d = 1'b0;
            end
        end
    end

    // Divider and capture registers.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            clk_o_q   <= 1'b0;
            cap_q     <= '0;
            cap_stb_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_o_q   <= clk_o_d;
            cap_q     <= cap_d;
            cap_stb_q <= cap_stb_d;
        end
    end

    ma_sliding_window #(
        .BITS_ADC  (BITS_ADC),
        .BITS_ACUM (BITS_ACUM),
        .K_WIDTH   (K_WIDTH)
    ) u_ma (
        .clk_i    (clk_i),
        .rst_n    (rst),
        .clear_i  (clear_i),
        .k_i      (k),
        .sample_i (cap_q),
        .stb_i    (cap_stb_q),
        .avg_o    (sample_out),
        .rdy_o    (rdy_out)
    );

    // The ADC drivers stay off only while reset is held.
    assign adc_oe = ~rst;
    assign clk_o  = clk_o_q;

endmodule

// File: tb/tb_adc_capture_avg.sv
// Self-checking bench for adc_capture_avg: sample-history model plus hand-computed expectations.
module tb_adc_capture_avg;

    logic        clk_i    = 1'b0;
    logic        rst      = 1'b0;
    logic        clear_i  = 1'b0;
    logic [31:0] dfac     = 32'd0;
    logic [1:0]  k        = 2'd0;
    logic [7:0]  adc_data = 8'd0;
    logic        adc_oe, clk_o, rdy_out;
    logic [7:0]  sample_out;

    int checks = 0;
    int errors = 0;

    adc_capture_avg dut (
        .clk_i             (clk_i),
        .rst               (rst),
        .clear_i           (clear_i),
        .decimation_factor (dfac),
        .k                 (k),
        .adc_data_i        (adc_data),
        .adc_oe            (adc_oe),
        .clk_o             (clk_o),
        .sample_out        (sample_out),
        .rdy_out           (rdy_out)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges since restart, and the list of captured samples (newest first).
    int   ecnt    = 0;
    bit   pend    = 1'b0;
    int   hist[$];
    logic m_clk   = 1'b0;
    logic m_rdy   = 1'b0;
    logic [7:0] m_sample = 8'd0;

    function automatic int avg_of(input int kk);
        int s = 0;
        for (int i = 0; i < (1 << kk) && i < hist.size(); i++) s += hist[i];
        return s >> kk;
    endfunction

    always @(posedge clk_i or negedge rst) begin
        if (!rst || clear_i) begin
            ecnt = 0; pend = 1'b0; hist.delete();
            m_clk = 1'b0; m_rdy = 1'b0; m_sample = 8'd0;
        end else begin
            int p;
            p = int'(dfac) + 1;
            ecnt++;
            m_rdy = pend;
            if (pend) m_sample = 8'(avg_of(int'(k)));
            pend = 1'b0;
            if (ecnt % (2 * p) == 0) begin
                hist.push_front(int'(adc_data));
                if (hist.size() > 16) void'(hist.pop_back());
                pend = 1'b1;
            end
            m_clk = ((ecnt / p) % 2) == 1;
        end
    end

    always @(negedge clk_i) begin
        chk("clk_o", clk_o, m_clk);
        chk("rdy_out", rdy_out, m_rdy);
        chk("sample_out", sample_out, m_sample);
        chk("adc_oe", adc_oe, !rst);
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!rdy_out && cyc < 200);
        if (!rdy_out) chk("rdy_timeout", rdy_out, 1);
    endtask

    task automatic expect_next(input string name, input int v);
        int c;
        wait_rdy(c);
        chk(name, sample_out, v);
    endtask

    task automatic restart(input int d, input int kk, input int data);
        tick();
        clear_i = 1'b1; dfac = 32'(d); k = 2'(kk); adc_data = 8'(data);
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        int c;
        // 1: reset values, adc_oe release
        @(negedge clk_i);
        chk("rst_clk_o", clk_o, 0);
        chk("rst_rdy", rdy_out, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_oe", adc_oe, 1);
        adc_data = 8'd100;
        tick();
        rst = 1'b1;
        @(negedge clk_i);
        chk("oe_release", adc_oe, 0);

        // 2: D=0, k=0, constant 100
        for (int i = 0; i < 3; i++) expect_next("d0k0_100", 100);
        wait_rdy(c);
        chk("period_d0", c, 2);

        // 3: D=0, k=2, constant 200 ramp
        restart(0, 2, 200);
        expect_next("ramp_50", 50);
        expect_next("ramp_100", 100);
        expect_next("ramp_150", 150);
        expect_next("ramp_200", 200);
        expect_next("ramp_200b", 200);

        // 4: D=2, k=1, step 0 -> 64
        restart(2, 1, 0);
        expect_next("d2_zero", 0);
        wait_rdy(c);
        chk("period_d2", c, 6);
        adc_data = 8'd64;
        expect_next("step_32", 32);
        expect_next("step_64", 64);

        // 5: k=3, alternating 0/255
        restart(0, 3, 0);
        for (int i = 0; i < 12; i++) begin
            wait_rdy(c);
            if (i >= 7) chk("alt_127", sample_out, 127);
            adc_data = (i % 2 == 0) ? 8'd255 : 8'd0;
        end

        // 6: mid-stream clear coinciding with a capture edge, then async reset
        restart(0, 2, 80);
        expect_next("pre_80a", 20);
        expect_next("pre_80b", 40);
        wait_rdy(c);
        clear_i = 1'b1;
        @(posedge clk_i);
        #2;
        clear_i = 1'b0;
        @(negedge clk_i);
        chk("no_rdy_clear", rdy_out, 0);
        expect_next("clr_20", 20);
        expect_next("clr_40", 40);
        expect_next("clr_60", 60);
        expect_next("clr_80", 80);
        tick();
        rst = 1'b0;
        @(negedge clk_i);
        chk("arst_oe", adc_oe, 1);
        chk("arst_sample", sample_out, 0);
        tick();
        rst = 1'b1;
        expect_next("arst_20", 20);
        expect_next("arst_40", 40);
        expect_next("arst_60", 60);
        expect_next("arst_80", 80);

        repeat (4) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
